// File: rtl/hazard_stall_control_pkg.sv
// Shared types and defaults for the hazard/stall controller: register address width,
// default MUL latency and the controller state encoding.
package hazard_stall_control_pkg;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned MUL_LAT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        MEM_WAIT = 2'd2
    } hsc_state_e;

endpackage

// File: rtl/hazard_stall_control_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on async active-low reset.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_control.sv
// Pipeline hazard/stall controller: load-use stall, multi-cycle MUL occupancy of EX,
// D-mem miss freeze and taken-branch flush, decoded into register enables/bubbles/flushes.
module hazard_stall_control
    import hazard_stall_control_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] if_id_src1,
    input  logic [REG_ADDR_W-1:0] if_id_src2,
    input  logic                  id_ex_memread,
    input  logic [REG_ADDR_W-1:0] id_ex_dest_reg,
    input  logic                  id_ex_is_mul,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_write,
    output logic                  ex_mem_write,
    output logic                  mem_wb_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_bubble,
    output logic                  mul_done,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int unsigned MC_W = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
    localparam logic [MC_W-1:0] MUL_INIT = MC_W'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

    hsc_state_e      state, state_n, eff;
    logic            resume_mul, resume_mul_n;
    logic            flush_pend, flush_pend_n;
    logic [MC_W-1:0] mul_cnt, mul_cnt_n;
    logic            freeze, load_use;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            resume_mul <= 1'b0;
            flush_pend <= 1'b0;
            mul_cnt    <= '0;
        end else begin
            state      <= state_n;
            resume_mul <= resume_mul_n;
            flush_pend <= flush_pend_n;
            mul_cnt    <= mul_cnt_n;
        end
    end

    always_comb begin
        freeze   = mem_req & ~mem_ready;
        load_use = id_ex_memread && (id_ex_dest_reg != '0) &&
                   ((id_ex_dest_reg == if_id_src1) || (id_ex_dest_reg == if_id_src2));
        // An unfrozen MEM_WAIT cycle behaves as the state it returns to.
        eff = state;
        if (state == MEM_WAIT) eff = resume_mul ? MUL_BUSY : IDLE;

        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        mem_wb_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        mul_done      = 1'b0;
        state_n       = state;
        resume_mul_n  = resume_mul;
        flush_pend_n  = flush_pend;
        mul_cnt_n     = mul_cnt;

        if (!reset) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_write  = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
        end else if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            state_n      = MEM_WAIT;
            resume_mul_n = (eff == MUL_BUSY);
            flush_pend_n = flush_pend | branch_taken;
        end else begin
            state_n      = eff;
            resume_mul_n = 1'b0;
            flush_pend_n = 1'b0;
            case (eff)
                IDLE: begin
                    if (id_ex_is_mul && (MUL_LAT > 1)) begin
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        id_ex_write   = 1'b0;
                        ex_mem_bubble = 1'b1;
                        state_n       = MUL_BUSY;
                        mul_cnt_n     = MUL_INIT;
                    end else begin
                        mul_done = id_ex_is_mul;
                        if (load_use) begin
                            pc_write     = 1'b0;
                            if_id_write  = 1'b0;
                            id_ex_bubble = 1'b1;
                        end
                    end
                end
                MUL_BUSY: begin
                    if (mul_cnt == '0) begin
                        mul_done = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        id_ex_write   = 1'b0;
                        ex_mem_bubble = 1'b1;
                        mul_cnt_n     = mul_cnt - 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
            if (branch_taken || flush_pend) begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~pc_write),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_hazard_stall_control.sv
// Directed self-checking bench for hazard_stall_control (MUL_LAT=4).
module tb_hazard_stall_control;
    import hazard_stall_control_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  if_id_src1, if_id_src2, id_ex_dest_reg;
    logic        id_ex_memread, id_ex_is_mul, branch_taken, mem_req, mem_ready;
    logic        pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic        if_id_flush, id_ex_bubble, ex_mem_bubble, mul_done;
    logic [31:0] stall_cycles;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    hazard_stall_control #(.MUL_LAT(4), .CNT_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_id_src1     (if_id_src1),
        .if_id_src2     (if_id_src2),
        .id_ex_memread  (id_ex_memread),
        .id_ex_dest_reg (id_ex_dest_reg),
        .id_ex_is_mul   (id_ex_is_mul),
        .branch_taken   (branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .id_ex_write    (id_ex_write),
        .ex_mem_write   (ex_mem_write),
        .mem_wb_write   (mem_wb_write),
        .if_id_flush    (if_id_flush),
        .id_ex_bubble   (id_ex_bubble),
        .ex_mem_bubble  (ex_mem_bubble),
        .mul_done       (mul_done),
        .stall_cycles   (stall_cycles)
    );

    // Expected output vector order: {pc, if_id, id_ex, ex_mem, mem_wb, flush, id_ex_bub, ex_mem_bub, mul_done}
    localparam logic [8:0] O_RUN   = 9'b11111_000_0;
    localparam logic [8:0] O_LU    = 9'b00111_010_0;
    localparam logic [8:0] O_BR    = 9'b11111_110_0;
    localparam logic [8:0] O_FRZ   = 9'b00000_000_0;
    localparam logic [8:0] O_MUL   = 9'b00011_001_0;
    localparam logic [8:0] O_DONE  = 9'b11111_000_1;
    localparam logic [8:0] O_RST   = 9'b00000_111_0;
    localparam logic [8:0] O_MULBR = 9'b11011_111_0;

    typedef struct packed {
        logic [4:0] src1;
        logic [4:0] src2;
        logic       memread;
        logic [4:0] dest;
        logic       branch;
        logic       req;
        logic       ready;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [8:0] exp);
        logic [8:0] got;
        got = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
               if_id_flush, id_ex_bubble, ex_mem_bubble, mul_done};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chk_stall(input string name, input logic [31:0] exp);
        checks++;
        if (stall_cycles !== exp) begin
            errors++;
            $display("FAIL %s: stall_cycles got %0d expected %0d", name, stall_cycles, exp);
        end
    endtask

    task automatic idle_inputs();
        if_id_src1 = 5'd1; if_id_src2 = 5'd2; id_ex_dest_reg = 5'd3;
        id_ex_memread = 1'b0; id_ex_is_mul = 1'b0; branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Drive current inputs for one cycle: sample at negedge, then move to just after posedge.
    task automatic cycle_chk(input string name, input logic [8:0] exp);
        @(negedge clk);
        chk(name, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int unsigned exp_stall;
        vecs[0]  = '{5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, O_RUN};
        vecs[1]  = '{5'd4, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[2]  = '{5'd7, 5'd9, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[3]  = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN};
        vecs[4]  = '{5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, O_RUN};
        vecs[5]  = '{5'd6, 5'd6, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, O_RUN};
        vecs[6]  = '{5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, O_BR};
        vecs[7]  = '{5'd8, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, O_BR};
        vecs[8]  = '{5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, O_FRZ};
        vecs[9]  = '{5'd5, 5'd2, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, O_FRZ};
        vecs[10] = '{5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, O_RUN};
        vecs[11] = '{5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, O_RUN};

        // Reset state
        idle_inputs();
        reset = 1'b0;
        #2;
        chk("reset_outputs", O_RST);
        chk_stall("reset_stall", 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single-cycle vector table
        exp_stall = 0;
        for (int i = 0; i < 12; i++) begin
            if_id_src1     = vecs[i].src1;
            if_id_src2     = vecs[i].src2;
            id_ex_memread  = vecs[i].memread;
            id_ex_dest_reg = vecs[i].dest;
            branch_taken   = vecs[i].branch;
            mem_req        = vecs[i].req;
            mem_ready      = vecs[i].ready;
            if (vecs[i].exp[8] == 1'b0) exp_stall++;
            cycle_chk($sformatf("vec%0d", i), vecs[i].exp);
        end
        idle_inputs();
        cycle_chk("table_tail", O_RUN);
        chk_stall("table_stall", exp_stall);

        // Load-use: exactly one stall cycle
        do_reset();
        id_ex_memread = 1'b1; id_ex_dest_reg = 5'd5; if_id_src2 = 5'd5;
        cycle_chk("lu_stall", O_LU);
        idle_inputs();
        cycle_chk("lu_after", O_RUN);
        chk_stall("lu_stall_cnt", 32'd1);

        // MUL occupies EX for 4 cycles
        do_reset();
        id_ex_is_mul = 1'b1;
        cycle_chk("mul_c1", O_MUL);
        id_ex_is_mul = 1'b0;
        cycle_chk("mul_c2", O_MUL);
        cycle_chk("mul_c3", O_MUL);
        cycle_chk("mul_done", O_DONE);
        cycle_chk("mul_after", O_RUN);
        chk_stall("mul_stall_cnt", 32'd3);

        // 5-cycle D-mem miss
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle_chk($sformatf("miss_c%0d", i), O_FRZ);
        mem_ready = 1'b1;
        cycle_chk("miss_resume", O_RUN);
        chk_stall("miss_stall_cnt", 32'd5);

        // Miss in MUL cycle 2, branch during miss -> deferred flush
        do_reset();
        id_ex_is_mul = 1'b1;
        cycle_chk("mm_c1", O_MUL);
        id_ex_is_mul = 1'b0;
        mem_req = 1'b1; mem_ready = 1'b0;
        cycle_chk("mm_frz1", O_FRZ);
        branch_taken = 1'b1;
        cycle_chk("mm_frz2_br", O_FRZ);
        branch_taken = 1'b0;
        cycle_chk("mm_frz3", O_FRZ);
        mem_ready = 1'b1;
        cycle_chk("mm_flush", O_MULBR);
        mem_req = 1'b0; mem_ready = 1'b0;
        cycle_chk("mm_c3", O_MUL);
        cycle_chk("mm_done", O_DONE);
        cycle_chk("mm_after", O_RUN);

        // Reset asserted mid-MUL
        do_reset();
        id_ex_is_mul = 1'b1;
        cycle_chk("rm_c1", O_MUL);
        id_ex_is_mul = 1'b0;
        cycle_chk("rm_c2", O_MUL);
        reset = 1'b0;
        #2;
        chk("rm_reset_outputs", O_RST);
        chk_stall("rm_reset_stall", 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) cycle_chk($sformatf("rm_post%0d", i), O_RUN);
        chk_stall("rm_post_stall", 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
